// File: rtl/divider_arbiter.sv
// Round-robin front end for one shared sequential divider: picks a requester,
// hands its operands to the divider, and routes the result (or a watchdog
// error) back tagged with the requester id.
module divider_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_dividend,
    input  logic [NUM_REQ*WIDTH-1:0]   req_divisor,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       resp_valid,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [WIDTH-1:0]           resp_quotient,
    output logic [WIDTH-1:0]           resp_remainder,
    output logic                       resp_error,
    output logic [WIDTH-1:0]           div_dividend,
    output logic [WIDTH-1:0]           div_divisor,
    output logic                       div_in_valid,
    input  logic [WIDTH-1:0]           div_quotient,
    input  logic [WIDTH-1:0]           div_remainder,
    input  logic                       div_out_valid,
    input  logic                       div_error,
    input  logic                       div_busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     last_grant_q, last_grant_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [WDW-1:0]     wd_q, wd_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic               resp_valid_q, resp_valid_d;
    logic [IDW-1:0]     resp_id_q, resp_id_d;
    logic [WIDTH-1:0]   resp_quotient_q, resp_quotient_d;
    logic [WIDTH-1:0]   resp_remainder_q, resp_remainder_d;
    logic               resp_error_q, resp_error_d;
    logic [WIDTH-1:0]   div_dividend_q, div_dividend_d;
    logic [WIDTH-1:0]   div_divisor_q, div_divisor_d;
    logic               div_in_valid_q, div_in_valid_d;

    logic [WIDTH-1:0]     dividend_arr [NUM_REQ];
    logic [WIDTH-1:0]     divisor_arr  [NUM_REQ];
    logic [2*NUM_REQ-1:0] req_rot;
    logic [IDW:0]         grant_start;
    logic [IDW:0]         grant_off;
    logic [IDW:0]         grant_sum;
    logic                 grant_found;
    logic [IDW-1:0]       grant_id;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign dividend_arr[gi] = req_dividend[gi*WIDTH +: WIDTH];
            assign divisor_arr[gi]  = req_divisor[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Rotate the request vector so the search starts just above the last winner.
    assign grant_start = {1'b0, last_grant_q} + (IDW+1)'(1);
    assign req_rot     = {req_valid, req_valid} >> grant_start;
    assign grant_sum   = grant_start + grant_off;
    assign grant_id    = (grant_sum >= (IDW+1)'(NUM_REQ)) ? IDW'(grant_sum - (IDW+1)'(NUM_REQ))
                                                          : IDW'(grant_sum);

    // Lowest set bit of the rotated vector is the round-robin winner offset.
    always_comb begin
        grant_found = 1'b0;
        grant_off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                grant_found = 1'b1;
                grant_off   = (IDW+1)'(k);
            end
        end
    end

    // Next-state and output logic for the grant / issue / wait sequence.
    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        id_d             = id_q;
        wd_d             = wd_q;
        req_ready_d      = '0;
        resp_valid_d     = 1'b0;
        div_in_valid_d   = 1'b0;
        resp_id_d        = resp_id_q;
        resp_quotient_d  = resp_quotient_q;
        resp_remainder_d = resp_remainder_q;
        resp_error_d     = resp_error_q;
        div_dividend_d   = div_dividend_q;
        div_divisor_d    = div_divisor_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    div_dividend_d = dividend_arr[grant_id];
                    div_divisor_d  = divisor_arr[grant_id];
                    id_d           = grant_id;
                    last_grant_d   = grant_id;
                    req_ready_d    = NUM_REQ'(1) << grant_id;
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!div_busy) begin
                    div_in_valid_d = 1'b1;
                    wd_d           = '0;
                    state_d        = S_WAIT;
                end
            end
            S_WAIT: begin
                // A real result wins over a watchdog expiry in the same cycle.
                if (div_out_valid) begin
                    resp_valid_d     = 1'b1;
                    resp_id_d        = id_q;
                    resp_quotient_d  = div_quotient;
                    resp_remainder_d = div_remainder;
                    resp_error_d     = div_error;
                    state_d          = S_IDLE;
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    resp_valid_d     = 1'b1;
                    resp_id_d        = id_q;
                    resp_quotient_d  = '0;
                    resp_remainder_d = '0;
                    resp_error_d     = 1'b1;
                    state_d          = S_IDLE;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            last_grant_q     <= IDW'(NUM_REQ - 1);
            id_q             <= '0;
            wd_q             <= '0;
            req_ready_q      <= '0;
            resp_valid_q     <= 1'b0;
            resp_id_q        <= '0;
            resp_quotient_q  <= '0;
            resp_remainder_q <= '0;
            resp_error_q     <= 1'b0;
            div_dividend_q   <= '0;
            div_divisor_q    <= '0;
            div_in_valid_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            last_grant_q     <= last_grant_d;
            id_q             <= id_d;
            wd_q             <= wd_d;
            req_ready_q      <= req_ready_d;
            resp_valid_q     <= resp_valid_d;
            resp_id_q        <= resp_id_d;
            resp_quotient_q  <= resp_quotient_d;
            resp_remainder_q <= resp_remainder_d;
            resp_error_q     <= resp_error_d;
            div_dividend_q   <= div_dividend_d;
            div_divisor_q    <= div_divisor_d;
            div_in_valid_q   <= div_in_valid_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_id        = resp_id_q;
    assign resp_quotient  = resp_quotient_q;
    assign resp_remainder = resp_remainder_q;
    assign resp_error     = resp_error_q;
    assign div_dividend   = div_dividend_q;
    assign div_divisor    = div_divisor_q;
    assign div_in_valid   = div_in_valid_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: a behavioural divider, queued requesters, a
// transaction-level reference checked every cycle, and directed scenarios.
module tb_divider_arbiter;

    localparam int N   = 2;
    localparam int W   = 32;
    localparam int LAT = 34;
    localparam int TOA = 1024;
    localparam int IDW = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main DUT signals
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_dividend, req_divisor;
    logic [N-1:0]   req_ready;
    logic           resp_valid, resp_error, div_in_valid;
    logic [IDW-1:0] resp_id;
    logic [W-1:0]   resp_quotient, resp_remainder, div_dividend, div_divisor;
    logic           div_busy;
    logic           busy_force = 1'b0;

    // behavioural divider
    logic         dm_out_valid = 1'b0, dm_err = 1'b0, dm_busy = 1'b0;
    logic [W-1:0] dm_q = '0, dm_r = '0, dm_a = '0, dm_b = '0;
    int           dm_cnt = 0;
    assign div_busy = dm_busy | busy_force;

    divider_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TOA)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_dividend(req_dividend), .req_divisor(req_divisor),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_quotient(resp_quotient), .resp_remainder(resp_remainder), .resp_error(resp_error),
        .div_dividend(div_dividend), .div_divisor(div_divisor), .div_in_valid(div_in_valid),
        .div_quotient(dm_q), .div_remainder(dm_r), .div_out_valid(dm_out_valid),
        .div_error(dm_err), .div_busy(div_busy)
    );

    // second instance with a short watchdog, divider inputs driven directly
    logic [N-1:0]   b_req_valid = '0;
    logic [N*W-1:0] b_req_dividend = {32'd9, 32'd9};
    logic [N*W-1:0] b_req_divisor  = {32'd3, 32'd3};
    logic [N-1:0]   b_req_ready;
    logic           b_resp_valid, b_resp_error, b_div_in_valid;
    logic [IDW-1:0] b_resp_id;
    logic [W-1:0]   b_resp_q, b_resp_r, b_div_dd, b_div_dv;
    logic           b_div_out_valid = 1'b0;
    logic [W-1:0]   b_div_q = 32'hDEAD, b_div_r = 32'hBEEF;

    divider_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(16)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_dividend(b_req_dividend), .req_divisor(b_req_divisor),
        .req_ready(b_req_ready), .resp_valid(b_resp_valid), .resp_id(b_resp_id),
        .resp_quotient(b_resp_q), .resp_remainder(b_resp_r), .resp_error(b_resp_error),
        .div_dividend(b_div_dd), .div_divisor(b_div_dv), .div_in_valid(b_div_in_valid),
        .div_quotient(b_div_q), .div_remainder(b_div_r), .div_out_valid(b_div_out_valid),
        .div_error(1'b0), .div_busy(1'b0)
    );

    // requesters: per-requester operand lists, popped on req_ready
    logic [W-1:0] op_a [N][16];
    logic [W-1:0] op_b [N][16];
    int           op_n [N];
    int           op_i [N];
    initial for (int i = 0; i < N; i++) begin op_n[i] = 0; op_i[i] = 0; end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = (op_i[i] < op_n[i]);
            req_dividend[i*W +: W] = req_valid[i] ? op_a[i][op_i[i][3:0]] : '0;
            req_divisor[i*W +: W]  = req_valid[i] ? op_b[i][op_i[i][3:0]] : '0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) op_i[i] <= op_i[i] + 1;
    end

    // divider: LAT cycles after accepting, one-cycle result; divide by zero flags error
    always @(posedge clk) begin
        dm_out_valid <= 1'b0;
        if (div_in_valid) begin
            dm_a <= div_dividend; dm_b <= div_divisor; dm_cnt <= LAT; dm_busy <= 1'b1;
        end else if (dm_cnt > 0) begin
            dm_cnt <= dm_cnt - 1;
            if (dm_cnt == 1) begin
                dm_out_valid <= 1'b1;
                dm_busy      <= 1'b0;
                dm_q         <= (dm_b == 0) ? '1 : dm_a / dm_b;
                dm_r         <= (dm_b == 0) ? dm_a : dm_a % dm_b;
                dm_err       <= (dm_b == 0);
            end
        end
    end

    // reference: one operation in flight, round-robin pick, watchdog by age
    logic [N-1:0]   exp_ready = '0;
    logic           exp_in_valid = 1'b0, exp_resp_valid = 1'b0, exp_err = 1'b0;
    logic [IDW-1:0] exp_id = '0;
    logic [W-1:0]   exp_q = '0, exp_r = '0, exp_dd = '0, exp_dv = '0;
    logic           m_active = 1'b0, m_sent = 1'b0;
    int             m_age = 0, m_last = N - 1, m_id = 0;

    always @(posedge clk) begin
        int g;
        exp_ready = '0; exp_in_valid = 1'b0; exp_resp_valid = 1'b0;
        if (rst) begin
            m_active = 1'b0; m_last = N - 1;
            exp_id = '0; exp_q = '0; exp_r = '0; exp_err = 1'b0; exp_dd = '0; exp_dv = '0;
        end else if (!m_active) begin
            g = -1;
            for (int k = 1; k <= N; k++) if (g < 0 && req_valid[(m_last + k) % N]) g = (m_last + k) % N;
            if (g >= 0) begin
                m_active = 1'b1; m_sent = 1'b0; m_id = g; m_last = g;
                exp_ready[g] = 1'b1;
                exp_dd = req_dividend[g*W +: W];
                exp_dv = req_divisor[g*W +: W];
            end
        end else if (!m_sent) begin
            if (!div_busy) begin m_sent = 1'b1; m_age = 0; exp_in_valid = 1'b1; end
        end else if (dm_out_valid) begin
            exp_resp_valid = 1'b1; exp_id = IDW'(m_id);
            exp_q = dm_q; exp_r = dm_r; exp_err = dm_err; m_active = 1'b0;
        end else if (m_age == TOA - 1) begin
            exp_resp_valid = 1'b1; exp_id = IDW'(m_id);
            exp_q = '0; exp_r = '0; exp_err = 1'b1; m_active = 1'b0;
        end else begin
            m_age++;
        end
    end

    // bookkeeping and checking, all from the stimulus process
    int n_checks = 0, n_fail = 0, cyc = 0;
    int g_log [64];
    int g_n = 0, iv_n = 0, iv_cyc = 0, g_cyc = 0;
    int r_id [64];
    logic [W-1:0] r_q [64], r_r [64];
    logic r_e [64];
    int r_n = 0;
    logic [N-1:0] prev_ready = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_all();
        int gid;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("div_in_valid", 64'(div_in_valid), 64'(exp_in_valid));
        check("resp_valid", 64'(resp_valid), 64'(exp_resp_valid));
        check("resp_id", 64'(resp_id), 64'(exp_id));
        check("resp_quotient", 64'(resp_quotient), 64'(exp_q));
        check("resp_remainder", 64'(resp_remainder), 64'(exp_r));
        check("resp_error", 64'(resp_error), 64'(exp_err));
        check("div_dividend", 64'(div_dividend), 64'(exp_dd));
        check("div_divisor", 64'(div_divisor), 64'(exp_dv));
        if (req_ready != 0) begin
            check("ready_onehot", 64'($onehot(req_ready)), 64'(1));
            check("ready_pulse", 64'(prev_ready), 64'(0));
            gid = 0;
            for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
            g_log[g_n[5:0]] = gid; g_n++; g_cyc = cyc;
        end
        if (div_in_valid) begin iv_n++; iv_cyc = cyc; end
        if (resp_valid) begin
            r_id[r_n[5:0]] = int'(resp_id); r_q[r_n[5:0]] = resp_quotient;
            r_r[r_n[5:0]] = resp_remainder; r_e[r_n[5:0]] = resp_error;
            $display("resp #%0d id=%0d q=%0d r=%0d err=%0d", r_n, resp_id, resp_quotient, resp_remainder, resp_error);
            r_n++;
        end
        prev_ready = req_ready;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic add_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
        op_a[r][op_n[r][3:0]] = a;
        op_b[r][op_n[r][3:0]] = b;
        op_n[r] = op_n[r] + 1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_resp(input int n, input int budget);
        int t = 0;
        while (r_n < n && t < budget) begin tick(); t++; end
        check("resp_arrived", 64'(r_n >= n), 64'(1));
    endtask

    initial begin
        int g0, r0, iv0, c0, c1, t, seen;
        int exp_order [6] = '{0, 1, 0, 1, 0, 1};

        // reset state
        tick(); tick();
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_div_dividend", 64'(div_dividend), 64'(0));
        rst = 1'b0;
        tick();

        // single request 100/7
        g0 = g_n; r0 = r_n; iv0 = iv_n;
        add_op(0, 100, 7);
        wait_resp(r0 + 1, LAT + 20);
        tick(); tick();
        check("t1_grants", 64'(g_n - g0), 64'(1));
        check("t1_issues", 64'(iv_n - iv0), 64'(1));
        check("t1_issue_latency", 64'(iv_cyc - g_cyc), 64'(1));
        check("t1_id", 64'(r_id[r0]), 64'(0));
        check("t1_q", 64'(r_q[r0]), 64'(14));
        check("t1_r", 64'(r_r[r0]), 64'(2));
        check("t1_err", 64'(r_e[r0]), 64'(0));

        // simultaneous requests after reset
        do_reset();
        g0 = g_n; r0 = r_n;
        add_op(0, 1000, 10);
        add_op(1, 999, 3);
        wait_resp(r0 + 2, 2 * (LAT + 20));
        check("t2_grant0", 64'(g_log[g0]), 64'(0));
        check("t2_grant1", 64'(g_log[g0 + 1]), 64'(1));
        check("t2_id0", 64'(r_id[r0]), 64'(0));
        check("t2_q0", 64'(r_q[r0]), 64'(100));
        check("t2_r0", 64'(r_r[r0]), 64'(0));
        check("t2_id1", 64'(r_id[r0 + 1]), 64'(1));
        check("t2_q1", 64'(r_q[r0 + 1]), 64'(333));
        check("t2_r1", 64'(r_r[r0 + 1]), 64'(0));

        // continuous contention, six operations
        do_reset();
        g0 = g_n; r0 = r_n;
        for (int i = 0; i < 3; i++) begin
            add_op(0, 10 * (i + 1), 3);
            add_op(1, 40 + 10 * i, 7);
        end
        wait_resp(r0 + 6, 6 * (LAT + 20));
        for (int i = 0; i < 6; i++) check($sformatf("t3_grant%0d", i), 64'(g_log[g0 + i]), 64'(exp_order[i]));
        check("t3_q0", 64'(r_q[r0]), 64'(3));
        check("t3_q5", 64'(r_q[r0 + 5]), 64'(8));

        // divide by zero, then a normal op
        do_reset();
        r0 = r_n;
        add_op(1, 5, 0);
        wait_resp(r0 + 1, LAT + 20);
        check("t4_id", 64'(r_id[r0]), 64'(1));
        check("t4_err", 64'(r_e[r0]), 64'(1));
        add_op(1, 8, 2);
        wait_resp(r0 + 2, LAT + 20);
        check("t4_q", 64'(r_q[r0 + 1]), 64'(4));
        check("t4_err2", 64'(r_e[r0 + 1]), 64'(0));

        // divider busy for 5 cycles after grant
        tick();
        g0 = g_n; r0 = r_n; iv0 = iv_n;
        add_op(0, 20, 4);
        t = 0;
        while (g_n == g0 && t < 5) begin tick(); t++; end
        check("t5_granted", 64'(g_n - g0), 64'(1));
        busy_force = 1'b1;
        repeat (5) tick();
        check("t5_held", 64'(iv_n - iv0), 64'(0));
        busy_force = 1'b0;
        t = 0;
        while (iv_n == iv0 && t < 5) begin tick(); t++; end
        check("t5_issue_delay", 64'(iv_cyc - g_cyc), 64'(6));
        wait_resp(r0 + 1, LAT + 20);
        check("t5_q", 64'(r_q[r0]), 64'(5));

        // reset while waiting; stale result must be dropped
        tick();
        r0 = r_n; iv0 = iv_n;
        add_op(0, 77, 7);
        t = 0;
        while (iv_n == iv0 && t < 10) begin tick(); t++; end
        check("t6_issued", 64'(iv_n - iv0), 64'(1));
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("t6_rst_resp_valid", 64'(resp_valid), 64'(0));
        check("t6_rst_quotient", 64'(resp_quotient), 64'(0));
        check("t6_rst_div_dividend", 64'(div_dividend), 64'(0));
        rst = 1'b0;
        repeat (LAT + 10) tick();
        check("t6_no_stale_resp", 64'(r_n - r0), 64'(0));

        // watchdog on the short-timeout instance
        do_reset();
        b_req_valid = 2'b01;
        t = 0;
        while (b_req_ready == 0 && t < 10) begin tick(); t++; end
        b_req_valid = '0;
        t = 0;
        while (!b_div_in_valid && t < 10) begin tick(); t++; end
        c0 = cyc;
        t = 0;
        while (!b_resp_valid && t < 40) begin tick(); t++; end
        c1 = cyc;
        check("t7_timeout_seen", 64'(b_resp_valid), 64'(1));
        check("t7_timeout_delay", 64'(c1 - c0), 64'(16));
        check("t7_err", 64'(b_resp_error), 64'(1));
        check("t7_q", 64'(b_resp_q), 64'(0));
        check("t7_r", 64'(b_resp_r), 64'(0));
        b_div_out_valid = 1'b1;
        tick();
        b_div_out_valid = 1'b0;
        seen = 0;
        repeat (5) begin tick(); if (b_resp_valid) seen++; end
        check("t7_late_ignored", 64'(seen), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
- Shares one external sequential divider among NUM_REQ requesters, e.g. the x and y channels of a centroid unit, or several centroid units.
- Arbitrates round-robin and latches the winner's operands.
- Sequences the divider's data_in_valid/busy/data_out_valid protocol.
- Returns each result to its requester, tagged with an id, and converts a hung divider into an error response through a watchdog.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- WIDTH, 32, dividend/divisor/quotient/remainder width.
- TIMEOUT, 1024, cycles to wait for div_out_valid before forcing an error response.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request; operands held stable until req_ready
- req_dividend  in  NUM_REQ*WIDTH  flattened dividends; requester i occupies bits [i*WIDTH +: WIDTH]
- req_divisor  in  NUM_REQ*WIDTH  flattened divisors, same packing as req_dividend
- req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot
- resp_valid  out  1  one-cycle result pulse
- resp_id  out  $clog2(NUM_REQ)  requester owning the result
- resp_quotient  out  WIDTH  quotient
- resp_remainder  out  WIDTH  remainder
- resp_error  out  1  divider error, or watchdog timeout
- div_dividend  out  WIDTH  to divider
- div_divisor  out  WIDTH  to divider
- div_in_valid  out  1  to divider, one-cycle pulse
- div_quotient  in  WIDTH  from divider
- div_remainder  in  WIDTH  from divider
- div_out_valid  in  1  from divider
- div_error  in  1  from divider
- div_busy  in  1  from divider

Behaviour:
- All outputs are registered.
- Reset values:
  - req_ready=0, resp_valid=0, resp_id=0, resp_quotient=0, resp_remainder=0, resp_error=0.
  - div_dividend=0, div_divisor=0, div_in_valid=0.
  - state=IDLE, last_grant=NUM_REQ-1, so requester 0 has first priority.
  - Watchdog counter=0.
- State machine IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE:
  - If any req_valid bit is set, grant the first set bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - On the next edge: latch that requester's operands into div_dividend/div_divisor, store the id, set last_grant=id, pulse req_ready[id] for one cycle, go to ISSUE.
  - Requests not granted stay pending; requesters keep req_valid asserted.
- ISSUE:
  - If div_busy=0: drive div_in_valid=1 for exactly one cycle, clear the watchdog, go to WAIT.
  - If div_busy=1: stay in ISSUE with div_in_valid=0.
- WAIT:
  - The watchdog increments every cycle.
  - On div_out_valid=1: on the next edge set resp_valid=1 for one cycle, with resp_id=stored id, resp_quotient/resp_remainder from div_quotient/div_remainder, resp_error=div_error. Then go to IDLE.
  - If the watchdog reaches TIMEOUT-1 without div_out_valid: set resp_valid=1, resp_error=1, resp_quotient=0, resp_remainder=0, then go to IDLE.
  - A div_out_valid in the same cycle as the timeout takes priority over the timeout.
- div_out_valid in IDLE or ISSUE: ignored; counts as a stale result.
- Divisor 0: forwarded unchanged to the divider. The error comes back through div_error, and resp_error=1 with whatever quotient the divider returns.
- At most one operation is in flight. resp_valid and req_ready may be high in the same cycle only when the response pulse and the IDLE grant coincide; this is not required, since the grant happens in the cycle after resp_valid.
- Throughput: the sequence is req_ready at edge k+1 after req_valid is seen at edge k; div_in_valid at k+2; resp_valid one edge after div_out_valid. Throughput is therefore one operation per divider latency + 3 cycles.
- Outputs that are not pulses (resp_*, div_dividend, div_divisor) hold their last value.
- Reset mid-operation:
  - Returns to IDLE with all reset values.
  - The in-flight result is dropped; a later div_out_valid is ignored.
  - The requester must re-request.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 other operations.

Test Plan:
- NUM_REQ=2, req0 only, 100/7, divider model with 34-cycle latency:
  - req_ready[0] pulses once, div_in_valid pulses once.
  - resp_valid with resp_id=0, quotient=14, remainder=2, error=0.
- req0=1000/10 and req1=999/3 raised in the same cycle after reset:
  - First grant is 0 (result 100, remainder 0), then 1 (result 333, remainder 0).
  - resp_id sequence is 0,1.
- Both requesters held continuously for 6 operations:
  - Grant order is 0,1,0,1,0,1.
  - Each req_ready pulse is exactly one cycle.
- req1 5/0, divider asserts error:
  - resp_id=1, resp_error=1.
  - The next request, 8/2, returns 4 with error=0.
- TIMEOUT=16, divider model never asserts div_out_valid:
  - resp_valid arrives 16 cycles after div_in_valid, with resp_error=1, quotient=0, remainder=0.
  - A div_out_valid arriving late while in IDLE is ignored.
- Divider held busy for 5 cycles after the grant: div_in_valid is delayed until div_busy=0.
- rst asserted in WAIT: outputs return to reset values, and a stale div_out_valid produces no resp_valid.
